// File: rtl/cam_cfg_seq_if.sv
// cam_cfg_seq_if -- handshake bundle between the camera configuration
// sequencer (master) and the table RAM / I2C sender it drives (slave).
//   tbl_rd   : table read strobe (master -> table)
//   tbl_addr : table read address (master -> table)
//   tbl_data : table word, valid the cycle after tbl_rd (table -> master)
//   i2c_req  : one-cycle transfer request (master -> sender)
//   cfg_data : word to transfer, stable until the transfer resolves
//   i2c_ack  : one-cycle "transfer OK" pulse (sender -> master)
//   i2c_nack : one-cycle "transfer failed" pulse (sender -> master)
interface cam_cfg_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              tbl_rd;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              i2c_req;
  logic [DATA_W-1:0] cfg_data;
  logic              i2c_ack;
  logic              i2c_nack;

  modport master (
    output tbl_rd, tbl_addr, i2c_req, cfg_data,
    input  tbl_data, i2c_ack, i2c_nack
  );

  modport slave (
    input  tbl_rd, tbl_addr, i2c_req, cfg_data,
    output tbl_data, i2c_ack, i2c_nack
  );
endinterface

// File: rtl/cam_cfg_seq.sv
// cam_cfg_seq -- walks a table of configuration words after power-up (or on
// a start pulse) and hands each one to an I2C sender, with a per-entry retry
// budget for nacks and ack timeouts.
//   clk_100   : sole clock, rising edge
//   rst_100   : synchronous active-low reset
//   start     : one-cycle pulse, honoured only in IDLE/DONE/ERROR
//   cfg_count : number of valid table entries, sampled when a run starts
//   bus       : table read + I2C request/response handshake (master side)
//   busy      : a run is in progress
//   done      : last run completed with every entry acked
//   err       : last run aborted after exhausting retries
//   err_idx   : entry index that caused the abort
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | out of reset, waiting for auto-start or a start pulse
// PWR_WAIT | power-up settle delay before the first transfer
// FETCH    | table read strobe for entry idx
// LATCH    | capture table word into cfg_data, clear retry count
// REQ      | one-cycle request to the I2C sender
// WAIT_ACK | waiting for ack / nack / timeout
// GAP      | idle spacing before the next fetch, re-send or completion
// DONE     | all entries acked
// ERROR    | entry err_idx failed more than MAX_RETRY re-sends
module cam_cfg_seq #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int PWR_DLY    = 1000,
  parameter int GAP_CYC    = 16,
  parameter int ACK_TMO    = 65535,
  parameter int MAX_RETRY  = 3,
  parameter bit AUTO_START = 1'b1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk_100,
  input  logic              rst_100,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_count,
  cam_cfg_seq_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_idx
);

  localparam int CNT_MAX = (PWR_DLY > GAP_CYC) ?
                           ((PWR_DLY > ACK_TMO) ? PWR_DLY : ACK_TMO) :
                           ((GAP_CYC > ACK_TMO) ? GAP_CYC : ACK_TMO);
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [CNT_W-1:0] PWR_LOAD = (PWR_DLY > 0) ? CNT_W'(PWR_DLY - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] TMO_LOAD = (ACK_TMO > 0) ? CNT_W'(ACK_TMO - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FETCH, LATCH, REQ, WAIT_ACK, GAP, DONE, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]    idx_q, idx_d, idx_n;
  logic [ADDR_W:0]    count_q, count_d;
  logic [RTY_W-1:0]   retry_q, retry_d, retry_n;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  err_idx_q, err_idx_d;
  logic               armed_q, armed_d;
  logic               after_ack_q, after_ack_d;

  always_ff @(posedge clk_100) begin
    if (!rst_100) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      retry_q     <= '0;
      data_q      <= '0;
      err_idx_q   <= '0;
      armed_q     <= AUTO_START;
      after_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      retry_q     <= retry_d;
      data_q      <= data_d;
      err_idx_q   <= err_idx_d;
      armed_q     <= armed_d;
      after_ack_q <= after_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    count_d     = count_q;
    retry_d     = retry_q;
    data_d      = data_q;
    err_idx_d   = err_idx_q;
    armed_d     = armed_q;
    after_ack_d = after_ack_q;
    idx_n       = idx_q + 1'b1;
    retry_n     = retry_q + 1'b1;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        // armed_q gives the single post-reset auto-start; it is only
        // consulted in IDLE so DONE/ERROR wait for an explicit start.
        if (start || (state_q == IDLE && armed_q)) begin
          armed_d   = 1'b0;
          count_d   = cfg_count;
          idx_d     = '0;
          err_idx_d = '0;
          if (PWR_DLY > 0) begin
            state_d = PWR_WAIT;
            cnt_d   = PWR_LOAD;
          end else begin
            state_d = (cfg_count == '0) ? DONE : FETCH;
          end
        end
      end
      PWR_WAIT: begin
        if (cnt_q == '0) state_d = (count_q == '0) ? DONE : FETCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        data_d  = bus.tbl_data;
        retry_d = '0;
        state_d = REQ;
      end
      REQ: begin
        cnt_d   = TMO_LOAD;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // nack beats a simultaneous ack; an ack on the last timeout cycle
        // still counts as an ack.
        if (bus.i2c_nack || (!bus.i2c_ack && cnt_q == '0)) begin
          retry_d = retry_n;
          if (retry_n > RTY_W'(MAX_RETRY)) begin
            state_d   = ERROR;
            err_idx_d = idx_q[ADDR_W-1:0];
          end else begin
            after_ack_d = 1'b0;
            if (GAP_CYC > 0) begin
              state_d = GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = REQ;
            end
          end
        end else if (bus.i2c_ack) begin
          idx_d       = idx_n;
          after_ack_d = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = (idx_n == count_q) ? DONE : FETCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (!after_ack_q)          state_d = REQ;
          else if (idx_q == count_q) state_d = DONE;
          else                       state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tbl_rd   = (state_q == FETCH);
  assign bus.tbl_addr = (state_q == FETCH) ? idx_q[ADDR_W-1:0] : '0;
  assign bus.i2c_req  = (state_q == REQ);
  assign bus.cfg_data = data_q;
  assign busy         = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERROR);
  assign err_idx      = err_idx_q;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// tb_cam_cfg_seq -- directed bench for cam_cfg_seq. A table model answers
// reads one cycle later, a responder answers each request from a queue of
// planned responses, and a monitor compares each request word against a
// queue of expected words.
module tb_cam_cfg_seq;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int PWR_DLY   = 4;
  localparam int GAP_CYC   = 2;
  localparam int ACK_TMO   = 16;
  localparam int MAX_RETRY = 2;

  localparam int RSP_ACK  = 0;
  localparam int RSP_NACK = 1;
  localparam int RSP_NONE = 2;
  localparam int RSP_BOTH = 3;

  logic              clk_100 = 1'b0;
  logic              rst_100;
  logic              start;
  logic [ADDR_W:0]   cfg_count;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_idx;

  cam_cfg_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cam_cfg_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PWR_DLY(PWR_DLY), .GAP_CYC(GAP_CYC),
    .ACK_TMO(ACK_TMO), .MAX_RETRY(MAX_RETRY), .AUTO_START(1'b1)
  ) dut (
    .clk_100(clk_100), .rst_100(rst_100), .start(start), .cfg_count(cfg_count),
    .bus(bus), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  always #5 clk_100 = ~clk_100;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk_100) if (bus.tbl_rd) bus.tbl_data <= mem[bus.tbl_addr];

  int cyc;
  always @(posedge clk_100) cyc <= cyc + 1;

  int                n_chk, n_pass;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_rd;
  int                rsp_q[$];
  int                rsp_rd;
  int                req_total, rd_total;
  int                req_cyc [64];
  int                rd_log  [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n;
    n = 0;
    while (req_total < target && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  function automatic int rd_count(input int base, input int a);
    int c;
    c = 0;
    for (int i = base; i < rd_total; i++) if (rd_log[i % 256] == a) c++;
    return c;
  endfunction

  task automatic check_zero(input string tag);
    check(tag, 32'({bus.i2c_req, bus.tbl_rd, bus.tbl_addr, busy, done, err, err_idx}), 32'd0);
    check({tag, "_cfg_data"}, bus.cfg_data, 32'd0);
  endtask

  task automatic plan(input int e0, input int r0);
    exp_q.push_back(mem[e0]);
    rsp_q.push_back(r0);
  endtask

  initial begin
    int b_req, b_rd;
    n_chk = 0; n_pass = 0; exp_rd = 0; rsp_rd = 0;
    req_total = 0; rd_total = 0; cyc = 0;
    mem[0] = 32'h5555AAAA; mem[1] = 32'h4444BBBB; mem[2] = 32'h3333CCCC;
    mem[3] = 32'hDEAD0003; mem[4] = 32'hDEAD0004; mem[5] = 32'hDEAD0005;
    mem[6] = 32'hDEAD0006; mem[7] = 32'hDEAD0007;
    rst_100 = 1'b0; start = 1'b0; cfg_count = 4'd3;
    bus.i2c_ack = 1'b0; bus.i2c_nack = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk_100);
          if (bus.tbl_rd) begin
            rd_log[rd_total % 256] = int'(bus.tbl_addr);
            rd_total++;
          end
          if (bus.i2c_req) begin
            req_cyc[req_total % 64] = cyc;
            req_total++;
            check("req_expected", 32'(exp_rd < exp_q.size()), 32'd1);
            if (exp_rd < exp_q.size()) begin
              check("req_data", bus.cfg_data, exp_q[exp_rd]);
              exp_rd++;
            end
          end
        end
      end
      begin : responder
        int                code;
        logic [DATA_W-1:0] held;
        bit                live;
        forever begin
          @(negedge clk_100);
          if (bus.i2c_req) begin
            code = (rsp_rd < rsp_q.size()) ? rsp_q[rsp_rd] : RSP_NONE;
            rsp_rd++;
            held = bus.cfg_data;
            live = 1'b1;
            if (code != RSP_NONE) begin
              repeat (3) begin
                @(negedge clk_100);
                if (!rst_100) live = 1'b0;
              end
              if (live) begin
                check("cfg_hold", bus.cfg_data, held);
                bus.i2c_ack  = (code == RSP_ACK  || code == RSP_BOTH);
                bus.i2c_nack = (code == RSP_NACK || code == RSP_BOTH);
                @(negedge clk_100);
                bus.i2c_ack  = 1'b0;
                bus.i2c_nack = 1'b0;
              end
            end
          end
        end
      end
    join_none

    // Reset state
    tick(3);
    check_zero("reset");

    // Auto-start run of three entries; a start while busy must be ignored
    plan(0, RSP_ACK); plan(1, RSP_ACK); plan(2, RSP_ACK);
    b_req = req_total; b_rd = rd_total;
    rst_100 = 1'b1;
    wait_reqs(b_req + 1, 200);
    check("s1_first_req_seen", 32'(req_total > b_req), 32'd1);
    pulse_start();
    wait_end(500);
    check("s1_done", 32'({done, err, busy}), 32'b100);
    check("s1_reqs", 32'(req_total - b_req), 32'd3);
    check("s1_rd_addr0_once", 32'(rd_count(b_rd, 0)), 32'd1);
    check("s1_no_rd_addr3", 32'(rd_count(b_rd, 3)), 32'd0);
    check("s1_scoreboard", 32'(exp_rd), 32'(exp_q.size()));

    // Entry 1 nacked twice (second one with a simultaneous ack), then acked
    plan(0, RSP_ACK); plan(1, RSP_NACK); plan(1, RSP_BOTH); plan(1, RSP_ACK);
    plan(2, RSP_ACK);
    b_req = req_total; b_rd = rd_total;
    pulse_start();
    check("s2_start_clears_done", 32'({done, busy}), 32'b01);
    wait_end(800);
    check("s2_done", 32'({done, err, busy}), 32'b100);
    check("s2_reqs", 32'(req_total - b_req), 32'd5);
    check("s2_rd_addr1_once", 32'(rd_count(b_rd, 1)), 32'd1);
    check("s2_rd_total", 32'(rd_total - b_rd), 32'd3);
    check("s2_scoreboard", 32'(exp_rd), 32'(exp_q.size()));

    // Entry 2 never answered: three timeouts, then abort
    plan(0, RSP_ACK); plan(1, RSP_ACK);
    plan(2, RSP_NONE); plan(2, RSP_NONE); plan(2, RSP_NONE);
    b_req = req_total; b_rd = rd_total;
    pulse_start();
    wait_end(800);
    check("s3_err", 32'({done, err, busy}), 32'b010);
    check("s3_err_idx", 32'(err_idx), 32'd2);
    check("s3_reqs", 32'(req_total - b_req), 32'd5);
    check("s3_retry_spacing1", 32'(req_cyc[(b_req + 3) % 64] - req_cyc[(b_req + 2) % 64]),
          32'(1 + ACK_TMO + GAP_CYC));
    check("s3_retry_spacing2", 32'(req_cyc[(b_req + 4) % 64] - req_cyc[(b_req + 3) % 64]),
          32'(1 + ACK_TMO + GAP_CYC));
    check("s3_scoreboard", 32'(exp_rd), 32'(exp_q.size()));

    // Start from ERROR clears the error and reruns from entry 0
    plan(0, RSP_ACK); plan(1, RSP_ACK); plan(2, RSP_ACK);
    b_req = req_total; b_rd = rd_total;
    pulse_start();
    check("s4_err_cleared", 32'({err, err_idx, busy}), 32'b00001);
    wait_end(500);
    check("s4_done", 32'({done, err, busy}), 32'b100);
    check("s4_first_rd_addr", 32'(rd_log[b_rd % 256]), 32'd0);
    check("s4_reqs", 32'(req_total - b_req), 32'd3);

    // Empty table: done after the power delay, no traffic
    cfg_count = 4'd0;
    b_req = req_total; b_rd = rd_total;
    pulse_start();
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin
        tick(1);
        n++;
      end
      check("s5_pwr_delay", 32'(n), 32'(PWR_DLY));
    end
    check("s5_no_reqs", 32'(req_total - b_req), 32'd0);
    check("s5_no_rds", 32'(rd_total - b_rd), 32'd0);

    // Reset during WAIT_ACK of entry 1, then auto-restart from entry 0
    cfg_count = 4'd3;
    plan(0, RSP_ACK); plan(1, RSP_NONE);
    b_req = req_total;
    pulse_start();
    wait_reqs(b_req + 2, 300);
    check("s6_reached_entry1", 32'(req_total - b_req), 32'd2);
    tick(3);
    rst_100 = 1'b0;
    tick(1);
    check_zero("s6_reset_next_edge");
    tick(2);
    plan(0, RSP_ACK); plan(1, RSP_ACK); plan(2, RSP_ACK);
    b_req = req_total; b_rd = rd_total;
    rst_100 = 1'b1;
    wait_end(500);
    check("s6_done", 32'({done, err, busy}), 32'b100);
    check("s6_first_rd_addr", 32'(rd_log[b_rd % 256]), 32'd0);
    check("s6_reqs", 32'(req_total - b_req), 32'd3);
    check("s6_scoreboard", 32'(exp_rd), 32'(exp_q.size()));
    check("rsp_consumed", 32'(rsp_rd), 32'(rsp_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_cfg_seq.md
CAM_CFG_SEQ -- requirements
Module: cam_cfg_seq

Interface
REQ-001 Parameter DATA_W, default 32: width of one configuration word passed to the I2C sender.
REQ-002 Parameter DEPTH, default 64: maximum number of table entries; ADDR_W = clog2(DEPTH).
REQ-003 Parameter PWR_DLY, default 1000: idle cycles after reset release before the first transfer.
REQ-004 Parameter GAP_CYC, default 16: idle cycles between consecutive transfers.
REQ-005 Parameter ACK_TMO, default 65535: cycles to wait for ack or nack before a timeout.
REQ-006 Parameter MAX_RETRY, default 3: re-sends allowed per entry after nack or timeout.
REQ-007 Parameter AUTO_START, default 1: when 1, the sequence runs once after reset without a start pulse.
REQ-008 clk_100  in  1  sole clock; all logic is clocked on its rising edge.
REQ-009 rst_100  in  1  synchronous, active-low reset.
REQ-010 start  in  1  one-cycle pulse that (re)runs the sequence; honoured only in IDLE, DONE or ERROR.
REQ-011 cfg_count  in  ADDR_W+1  number of valid entries (0..DEPTH); sampled on leaving IDLE/DONE/ERROR.
REQ-012 tbl_rd  out  1  table read strobe.
REQ-013 tbl_addr  out  ADDR_W  table read address.
REQ-014 tbl_data  in  DATA_W  table word, valid exactly one cycle after tbl_rd.
REQ-015 i2c_req  out  1  one-cycle transfer request to the I2C sender.
REQ-016 cfg_data  out  DATA_W  word to send; held stable from i2c_req until ack, nack or timeout.
REQ-017 i2c_ack  in  1  one-cycle pulse: transfer completed OK.
REQ-018 i2c_nack  in  1  one-cycle pulse: transfer failed.
REQ-019 busy / done / err  out  1 each  sequence running / completed OK / aborted.
REQ-020 err_idx  out  ADDR_W  index of the entry that caused the abort.

Function
REQ-021 States: IDLE, PWR_WAIT, FETCH, LATCH, REQ, WAIT_ACK, GAP, DONE, ERROR; encoding is free.
REQ-022 IDLE->PWR_WAIT on start, or on the first cycle after reset when AUTO_START=1.
REQ-023 PWR_WAIT runs for exactly PWR_DLY cycles (0 = skip), sets idx=0 and latches cfg_count, then enters FETCH; when the latched count is 0 it enters DONE with no i2c_req.
REQ-024 FETCH: tbl_rd=1 and tbl_addr=idx for one cycle. LATCH: cfg_data<=tbl_data, retry count cleared.
REQ-025 REQ: i2c_req=1 for exactly one cycle, then WAIT_ACK with the timeout counter cleared.
REQ-026 WAIT_ACK: on ack, idx increments and the block enters GAP; on nack or after ACK_TMO cycles, retry count increments.
REQ-027 After a nack or timeout, if the retry count is <= MAX_RETRY the block goes to GAP then REQ with the same cfg_data (no re-fetch); otherwise it enters ERROR with err_idx=idx.
REQ-028 GAP holds for GAP_CYC cycles, then goes to FETCH (after ack) or REQ (after retry); after an ack with idx==count, it goes to DONE.
REQ-029 When ack and nack arrive in the same cycle, nack wins; ack or nack outside WAIT_ACK is ignored.
REQ-030 busy=1 in every state except IDLE, DONE and ERROR; done=1 only in DONE; err=1 only in ERROR.
REQ-031 start from DONE or ERROR clears done, err and err_idx, then behaves as from IDLE; start while busy is ignored.
REQ-032 An ack in the cycle the timeout expires counts as an ack.

Reset
REQ-033 While rst_100=0, on every clock: state=IDLE, i2c_req=0, tbl_rd=0, tbl_addr=0, cfg_data=0, busy=0, done=0, err=0, err_idx=0, and all counters=0.
REQ-034 Reset asserted mid-transfer takes effect on the next edge; after release the block restarts from IDLE and sends no partial or pending request.

Verification
(parameters: DEPTH=8, PWR_DLY=4, GAP_CYC=2, ACK_TMO=16, MAX_RETRY=2, AUTO_START=1)
REQ-035 Table {5555AAAA, 4444BBBB, 3333CCCC}, cfg_count=3, ack 3 cycles after each req -> 3 req pulses carrying those words in order, done=1, no tbl_rd at address 3.
REQ-036 Entry 1 nacked twice then acked -> 4444BBBB sent 3 times, only one tbl_rd at address 1, sequence ends done=1.
REQ-037 Entry 2 never acked -> three reqs each 16-cycle timeout apart (plus gap), then err=1, err_idx=2, busy=0.
REQ-038 cfg_count=0 -> done=1 after the power delay, with zero i2c_req and zero tbl_rd.
REQ-039 rst_100 pulled low during WAIT_ACK of entry 1 -> all outputs zero next edge; after release, restart fetches address 0.
REQ-040 start pulse while busy is ignored; start pulse in ERROR clears err and reruns the sequence from entry 0.
